// File: rtl/ysyx_22050039_mem_arbiter_pkg.sv
// Shared encodings for the IFU/LSU memory-port arbiter.
package ysyx_22050039_mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2
  } state_e;

  // Transaction owner; also the value recorded as the last grant.
  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

  // Bit positions inside the 2-bit req/gnt vectors.
  localparam int unsigned ReqIfu = 0;
  localparam int unsigned ReqLsu = 1;

endpackage

// File: rtl/ysyx_22050039_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time is chosen.
module ysyx_22050039_rr_arb2
  import ysyx_22050039_mem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Grant the sole requester, or the one not equal to last on a tie.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last == logic'(OwnIfu)) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/ysyx_22050039_mem_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction outstanding at a time.
// The grant stays with its owner from request handshake until the memory response.
module ysyx_22050039_mem_arbiter
  import ysyx_22050039_mem_arbiter_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [XLEN-1:0]   ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [XLEN-1:0]   lsu_addr,
  input  logic              lsu_wen,
  input  logic [XLEN-1:0]   lsu_wdata,
  input  logic [XLEN/8-1:0] lsu_wmask,
  output logic              lsu_resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic              mem_wen,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wmask,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              last_q, last_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                wen_q, wen_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN/8-1:0]   wmask_q, wmask_d;
  logic [1:0]          gnt;

  ysyx_22050039_rr_arb2 u_rr_arb2 (
    .req  ({lsu_req_valid, ifu_req_valid}),
    .last (last_q),
    .gnt  (gnt)
  );

  // Next-state and output decode; grants are only offered while idle.
  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    resp_rdata     = '0;
    mem_req_valid  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gnt != 2'b00) begin
          ifu_req_ready = gnt[ReqIfu];
          lsu_req_ready = gnt[ReqLsu];
          state_d       = StIssue;
          if (gnt[ReqLsu]) begin
            owner_d = OwnLsu;
            addr_d  = lsu_addr;
            wen_d   = lsu_wen;
            wdata_d = lsu_wdata;
            wmask_d = lsu_wmask;
          end else begin
            // Fetches are read-only: never carry write enables or data.
            owner_d = OwnIfu;
            addr_d  = ifu_addr;
            wen_d   = 1'b0;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      StIssue: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = StWait;
      end
      StWait: begin
        if (mem_resp_valid) begin
          ifu_resp_valid = (owner_q == OwnIfu);
          lsu_resp_valid = (owner_q == OwnLsu);
          resp_rdata     = mem_rdata;
          last_d         = owner_q;
          state_d        = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched request fields; reset drops any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= OwnIfu;
      last_q  <= OwnIfu;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wen   = wen_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_ysyx_22050039_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: table of transactions plus
// hand-written reset and stray-input sequences, responses checked via a scoreboard.
module tb_ysyx_22050039_mem_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [XLEN-1:0] ifu_addr;
  logic            lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [XLEN-1:0] lsu_addr, lsu_wdata;
  logic [7:0]      lsu_wmask;
  logic [XLEN-1:0] resp_rdata;
  logic            mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]      mem_wmask;

  ysyx_22050039_mem_arbiter #(.XLEN(XLEN)) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ifu_v;
    bit          lsu_v;
    bit          exp_lsu;
    logic [63:0] ifu_a;
    logic [63:0] lsu_a;
    bit          wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
    int          rdy_dly;
    int          rsp_dly;
    bit          stray;
    logic [63:0] rdata;
  } txn_t;

  typedef struct {
    bit          lsu;
    logic [63:0] rdata;
  } exp_t;

  exp_t sb[$];
  txn_t tbl[10];
  int   tests = 0;
  int   fails = 0;
  bit   expect_hs = 1'b0;
  bit   hs_ifu, hs_lsu;

  function automatic txn_t mk(input bit iv, input bit lv, input bit el, input logic [63:0] ia,
                              input logic [63:0] la, input bit w, input logic [63:0] wd,
                              input logic [7:0] wm, input int rd, input int sd, input bit st,
                              input logic [63:0] rdat);
    txn_t t;
    t.ifu_v = iv; t.lsu_v = lv; t.exp_lsu = el; t.ifu_a = ia; t.lsu_a = la; t.wen = w;
    t.wdata = wd; t.wmask = wm; t.rdy_dly = rd; t.rsp_dly = sd; t.stray = st; t.rdata = rdat;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: exclusivity, unexpected grants, scoreboard on responses.
  task automatic mon();
    exp_t e;
    hs_ifu = ifu_req_valid && ifu_req_ready;
    hs_lsu = lsu_req_valid && lsu_req_ready;
    chk("ready_excl", 64'(ifu_req_ready & lsu_req_ready), 64'd0);
    chk("resp_excl", 64'(ifu_resp_valid & lsu_resp_valid), 64'd0);
    if ((hs_ifu || hs_lsu) && !expect_hs) begin
      tests++; fails++;
      $display("FAIL unexpected_grant: got ifu=%0d lsu=%0d expected none (t=%0t)",
               hs_ifu, hs_lsu, $time);
    end
    if (ifu_resp_valid || lsu_resp_valid) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_resp: got ifu=%0d lsu=%0d expected none (t=%0t)",
                 ifu_resp_valid, lsu_resp_valid, $time);
      end else begin
        e = sb.pop_front();
        chk("resp_owner_lsu", 64'(lsu_resp_valid), 64'(e.lsu));
        chk("resp_rdata", resp_rdata, e.rdata);
      end
    end else begin
      chk("resp_rdata_zero", resp_rdata, 64'd0);
    end
  endtask

  task automatic cyc();
    #1;
    mon();
    @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string name);
    chk({name, "_ifu_ready"}, 64'(ifu_req_ready), 64'd0);
    chk({name, "_lsu_ready"}, 64'(lsu_req_ready), 64'd0);
    chk({name, "_ifu_resp"}, 64'(ifu_resp_valid), 64'd0);
    chk({name, "_lsu_resp"}, 64'(lsu_resp_valid), 64'd0);
    chk({name, "_rdata"}, resp_rdata, 64'd0);
    chk({name, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
    chk({name, "_mem_addr"}, mem_addr, 64'd0);
    chk({name, "_mem_wen"}, 64'(mem_wen), 64'd0);
    chk({name, "_mem_wdata"}, mem_wdata, 64'd0);
    chk({name, "_mem_wmask"}, 64'(mem_wmask), 64'd0);
  endtask

  // Idle cycle with stray memory handshakes: nothing may be issued or answered.
  task automatic stray_idle_cyc(input string name);
    #1;
    chk({name, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
    mon();
    @(negedge clk);
  endtask

  task automatic do_txn(input txn_t t);
    logic [63:0] ea, ed;
    logic        ew;
    logic [7:0]  em;
    bit          got;
    exp_t        e;
    ifu_req_valid = t.ifu_v; ifu_addr = t.ifu_a;
    lsu_req_valid = t.lsu_v; lsu_addr = t.lsu_a;
    lsu_wen = t.wen; lsu_wdata = t.wdata; lsu_wmask = t.wmask;
    expect_hs = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 4 && !got; i++) begin
      cyc();
      if (hs_ifu || hs_lsu) got = 1'b1;
    end
    expect_hs = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL grant_timeout: got no handshake expected one within 4 cycles");
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
      return;
    end
    chk("grant_is_lsu", 64'(hs_lsu), 64'(t.exp_lsu));
    e.lsu = t.exp_lsu; e.rdata = t.rdata;
    sb.push_back(e);
    if (t.exp_lsu) begin
      lsu_req_valid = 1'b0;
      ea = t.lsu_a; ew = t.wen; ed = t.wdata; em = t.wmask;
    end else begin
      ifu_req_valid = 1'b0;
      ea = t.ifu_a; ew = 1'b0; ed = 64'd0; em = 8'd0;
    end
    for (int i = 0; i <= t.rdy_dly; i++) begin
      mem_req_ready  = (i == t.rdy_dly);
      mem_resp_valid = t.stray && (i == 0) && (t.rdy_dly > 0);
      mem_rdata      = 64'hbad0_bad0_bad0_bad0;
      #1;
      chk("issue_valid", 64'(mem_req_valid), 64'd1);
      chk("issue_addr", mem_addr, ea);
      chk("issue_wen", 64'(mem_wen), 64'(ew));
      chk("issue_wdata", mem_wdata, ed);
      chk("issue_wmask", 64'(mem_wmask), 64'(em));
      mon();
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i <= t.rsp_dly; i++) begin
      mem_resp_valid = (i == t.rsp_dly);
      mem_rdata      = (i == t.rsp_dly) ? t.rdata : 64'h5a5a_5a5a_5a5a_5a5a;
      #1;
      chk("wait_mem_valid", 64'(mem_req_valid), 64'd0);
      if (i == t.rsp_dly) chk("resp_pulse", 64'(ifu_resp_valid | lsu_resp_valid), 64'd1);
      else                chk("resp_early", 64'(ifu_resp_valid | lsu_resp_valid), 64'd0);
      mon();
      @(negedge clk);
    end
    mem_resp_valid = 1'b0;
    mem_rdata      = 64'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected completion before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Six back-to-back ties alternate starting with LSU, then the directed cases.
    for (int k = 0; k < 6; k++) begin
      tbl[k] = mk(1'b1, 1'b1, (k % 2) == 0, 64'h8000_0100 + 64'(k * 4), 64'h8000_2000 + 64'(k * 8),
                  (k % 4) == 0, 64'h1111_0000 + 64'(k), 8'hf0, k % 2, k % 3, 1'b0,
                  64'hc0de_0000 + 64'(k));
    end
    tbl[6] = mk(1'b1, 1'b0, 1'b0, 64'h8000_0000, 64'd0, 1'b0, 64'd0, 8'd0, 0, 0, 1'b0,
                64'h0000_0413);
    tbl[7] = mk(1'b0, 1'b1, 1'b1, 64'd0, 64'h8000_1000, 1'b1, 64'hdead_beef, 8'h0f, 3, 1, 1'b0,
                64'd0);
    tbl[8] = mk(1'b1, 1'b0, 1'b0, 64'h8000_0008, 64'd0, 1'b0, 64'd0, 8'd0, 2, 0, 1'b1,
                64'h0010_0093);
    tbl[9] = mk(1'b0, 1'b1, 1'b1, 64'd0, 64'h8000_3008, 1'b0, 64'hffff, 8'hff, 0, 2, 1'b0,
                64'h0123_4567_89ab_cdef);

    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_addr = 64'd0;
    lsu_req_valid = 1'b0; lsu_addr = 64'd0; lsu_wen = 1'b0; lsu_wdata = 64'd0; lsu_wmask = 8'd0;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'hffff_ffff_ffff_ffff;

    // Reset held with stray memory inputs: every output must read zero.
    repeat (2) @(negedge clk);
    #1;
    chk_reset_outs("t1_reset");
    @(negedge clk);
    rst = 1'b0;
    stray_idle_cyc("t1_after_reset");
    stray_idle_cyc("t1_after_reset");
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'd0;

    for (int k = 0; k < 10; k++) begin
      if (k == 8) begin
        // Stray memory inputs while idle, before the stray-in-ISSUE row.
        mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 64'h7777;
        stray_idle_cyc("t5_idle_stray");
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 64'd0;
      end
      do_txn(tbl[k]);
    end

    // Reset during WAIT drops the fetch; a late response must be ignored.
    ifu_req_valid = 1'b1; ifu_addr = 64'h8000_0040;
    expect_hs = 1'b1;
    cyc();
    expect_hs = 1'b0;
    chk("t6_grant_ifu", 64'(hs_ifu), 64'd1);
    ifu_req_valid = 1'b0;
    mem_req_ready = 1'b1;
    cyc();
    mem_req_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk_reset_outs("t6_reset");
    @(negedge clk);
    rst = 1'b0;
    mem_resp_valid = 1'b1; mem_rdata = 64'h0bad_f00d;
    stray_idle_cyc("t6_late_resp");
    stray_idle_cyc("t6_late_resp");
    mem_resp_valid = 1'b0; mem_rdata = 64'd0;
    do_txn(mk(1'b1, 1'b0, 1'b0, 64'h8000_0044, 64'd0, 1'b0, 64'd0, 8'd0, 0, 0, 1'b0,
              64'h0000_0013));
    cyc();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
